dvs_fifo_bus_scheduler: RTL

DVS_FIFO_BUS_SCHEDULER -- requirements
Module: dvs_fifo_bus_scheduler

---
 rtl/dvs_fifo_bus_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/dvs_fifo_bus_scheduler.sv
// Two-master event-FIFO bus scheduler with bounded bursts and a mandatory turnaround cycle.
// Optional writer-stall statistics counter is built only when DVS_SCHED_STATS_EN is defined.
module dvs_fifo_bus_scheduler #(
  parameter int BURST_MAX      = 16,
  parameter int STALL_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_wr,
  input  logic                      req_rd,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic                      stats_clr,
  output logic                      grant_wr,
  output logic                      grant_rd,
  output logic [STALL_CNT_BITS-1:0] wr_stall_cnt
);

  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD, TURN} state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic          r_grant_wr;
  logic          r_grant_rd;
  logic          r_last_wr;   // 1: writer owned the bus last, so reader wins the next tie
  logic [BW-1:0] r_burst;

  logic w_wr_ok;
  logic w_rd_ok;
  logic w_burst_last;
  logic w_enter_wr;
  logic w_enter_rd;
  logic w_stay;

  assign w_wr_ok      = req_wr & ~fifo_full;
  assign w_rd_ok      = req_rd & ~fifo_empty;
  assign w_burst_last = (r_burst == BURST_LAST);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE, TURN: begin
        if (w_wr_ok && w_rd_ok) w_nxt = r_last_wr ? GNT_RD : GNT_WR;
        else if (w_wr_ok)       w_nxt = GNT_WR;
        else if (w_rd_ok)       w_nxt = GNT_RD;
        else                    w_nxt = IDLE;
      end
      GNT_WR: begin
        if (!req_wr || fifo_full || (w_burst_last && w_rd_ok)) w_nxt = TURN;
      end
      GNT_RD: begin
        if (!req_rd || fifo_empty || (w_burst_last && w_wr_ok)) w_nxt = TURN;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Grant states are only reachable from IDLE/TURN, so any transition into one is an entry.
  assign w_enter_wr = (w_nxt == GNT_WR) && (r_state != GNT_WR);
  assign w_enter_rd = (w_nxt == GNT_RD) && (r_state != GNT_RD);
  assign w_stay     = (w_nxt == r_state) && ((r_state == GNT_WR) || (r_state == GNT_RD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant_wr <= 1'b0;
      r_grant_rd <= 1'b0;
      r_last_wr  <= 1'b0;
      r_burst    <= '0;
    end else begin
      r_state    <= w_nxt;
      r_grant_wr <= (w_nxt == GNT_WR);
      r_grant_rd <= (w_nxt == GNT_RD);
      if (w_enter_wr) r_last_wr <= 1'b1;
      else if (w_enter_rd) r_last_wr <= 1'b0;
      if (w_enter_wr || w_enter_rd) r_burst <= '0;
      else if (w_stay && !w_burst_last) r_burst <= r_burst + 1'b1;
    end
  end

  assign grant_wr = r_grant_wr;
  assign grant_rd = r_grant_rd;

`ifdef DVS_SCHED_STATS_EN
  logic [STALL_CNT_BITS-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) r_stall_cnt <= '0;
    else if (req_wr && !r_grant_wr && (r_stall_cnt != {STALL_CNT_BITS{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign wr_stall_cnt = r_stall_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = stats_clr;
  assign wr_stall_cnt   = '0;
`endif

endmodule
